multicycle_controller: RTL

Control FSM that sequences a multicycle RV32I datapath: one shared memory port, IR/OldPC/ALUOut/Data holding registers, one ALU reused for PC increment, branch target and execute. Decodes the latched instruction, walks each instruction through Fetch→Decode→Execute→(Mem)→Writeback, and drives every datapath select and enable. Adds a memory-ready wait handshake and a retired-instruction counter. Subset: lw, sw, R-type ALU, I-type ALU, beq, jal.

---
 rtl/multicycle_controller_pkg.sv | 53 +++++
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller_alu_decoder.sv | 29 ++
 rtl/multicycle_controller.sv | 136 +++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath:
// states, opcodes, ALU codes and datapath select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: decoded instruction fields and status in,
// selects/enables and debug state out.
// Handshake: MemReady=1 means memory completes the access presented this
// cycle; the FSM holds in FETCH/MEMREAD/MEMWRITE while MemReady=0.
interface multicycle_controller_if #(parameter int CNT_W = 32);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ImmSrc;
  logic [2:0]       ALUControl;
  logic             RegWrite;
  logic             Illegal;
  logic [CNT_W-1:0] InstRet;
  logic [3:0]       State;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, Illegal, InstRet, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, Illegal, InstRet, State
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control decode from ALUOp and the instruction function bits.
import multicycle_controller_pkg::*;

module multicycle_controller_alu_decoder (
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // Only register-register ops with funct7[5] subtract; addi never does.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory-ready stalls, sticky illegal-opcode
// flag and retired-instruction counter.
import multicycle_controller_pkg::*;

module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_controller_if.master      bus
);
  state_t           state;
  logic             illegal;
  logic [CNT_W-1:0] inst_ret;
  logic             retire;
  logic [1:0]       aluop;
  logic             pc_update;
  logic             branch;

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && bus.MemReady);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      illegal  <= 1'b0;
      inst_ret <= '0;
    end else begin
      if (retire) inst_ret <= inst_ret + CNT_W'(1);
      case (state)
        S_FETCH:    if (bus.MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTER;
            OP_ITYPE:     state <= S_EXECUTEI;
            OP_BEQ:       state <= S_BEQ;
            OP_JAL:       state <= S_JAL;
            default: begin
              state   <= S_FETCH;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   state <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.MemReady) state <= S_MEMWB;
        S_MEMWRITE: if (bus.MemReady) state <= S_FETCH;
        S_MEMWB, S_ALUWB, S_BEQ: state <= S_FETCH;
        S_EXECUTER, S_EXECUTEI, S_JAL: state <= S_ALUWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; only the FETCH enables and the branch see live status inputs.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    aluop         = ALUOP_ADD;
    bus.AdrSrc    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RS2;
    bus.RegWrite  = 1'b0;
    case (state)
      S_FETCH: begin
        bus.IRWrite   = bus.MemReady;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        pc_update     = bus.MemReady;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  bus.AdrSrc = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        bus.ALUSrcA = SRCA_RS1;
        aluop       = ALUOP_FUNC;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        aluop       = ALUOP_FUNC;
      end
      S_ALUWB:    bus.RegWrite = 1'b1;
      S_BEQ: begin
        bus.ALUSrcA = SRCA_RS1;
        aluop       = ALUOP_SUB;
        branch      = 1'b1;
      end
      S_JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_update   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = IMM_S;
      OP_BEQ:  bus.ImmSrc = IMM_B;
      OP_JAL:  bus.ImmSrc = IMM_J;
      default: bus.ImmSrc = IMM_I;
    endcase
  end

  multicycle_controller_alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (bus.ALUControl)
  );

  assign bus.PCWrite = pc_update | (branch & bus.Zero);
  assign bus.Illegal = illegal;
  assign bus.InstRet = inst_ret;
  assign bus.State   = state;
endmodule
